// File: rtl/uv_rst_seq.sv
// Reset sequencer: merges chip reset with sw/wdt/dbg requests, holds all domain resets,
// then releases the domains in index order with a fixed gap. Keeps a sticky reset-cause record.
module uv_rst_seq #(
    parameter int DOMAINS     = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int SYNC_STAGE  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_rst_req,
    input  logic               wdt_rst_req,
    input  logic               dbg_rst_req,
    input  logic               cause_clr,
    output logic [DOMAINS-1:0] domain_rst_n,
    output logic               rst_busy,
    output logic [3:0]         rst_cause
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(DOMAINS + 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGE-1:0] sync_q;
    logic                  srst_n;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DOMAINS-1:0]   dom_q, dom_d;
    logic                 busy_q;
    logic [3:0]           cause_q, cause_d;
    logic                 trig;

    // Assertion is immediate through the flop async resets; release waits SYNC_STAGE edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGE-2:0], 1'b1};
    end
    assign srst_n = sync_q[SYNC_STAGE-1];

    assign trig = sw_rst_req | wdt_rst_req | dbg_rst_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        cause_d = (cause_clr ? 4'b0000 : cause_q) | {dbg_rst_req, wdt_rst_req, sw_rst_req, 1'b0};

        if (trig) begin
            // Any request restarts the whole sequence, including already released domains.
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    dom_d = '0;
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        cnt_d    = '0;
                        dom_d[0] = 1'b1;
                        if (DOMAINS == 1) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_RELEASE;
                            idx_d   = IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        cnt_d = '0;
                        for (int i = 0; i < DOMAINS; i++) begin
                            if (idx_q == IW'(i)) dom_d[i] = 1'b1;
                        end
                        if (idx_q == IW'(DOMAINS - 1)) state_d = ST_RUN;
                        else                           idx_d   = idx_q + IW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RUN: begin
                    dom_d = '1;
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dom_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            busy_q  <= 1'b1;
            cause_q <= 4'b0001;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            busy_q  <= (state_d != ST_RUN);
            cause_q <= cause_d;
        end
    end

    assign domain_rst_n = dom_q;
    assign rst_busy     = busy_q;
    assign rst_cause    = cause_q;

endmodule

// File: tb/tb_uv_rst_seq.sv
// Directed bench for uv_rst_seq: expected domain/busy/cause values are queued per edge
// number when stimulus is applied and compared when the clock reaches that edge.
module tb_uv_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_rst_req, wdt_rst_req, dbg_rst_req, cause_clr;
    logic [2:0] domain_rst_n;
    logic       rst_busy;
    logic [3:0] rst_cause;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        string      tag;
        int         e;
        logic [2:0] dom;
        logic       busy;
        logic [3:0] cause;
    } exp_t;

    exp_t sb[$];

    uv_rst_seq #(.DOMAINS(3), .HOLD_CYCLES(16), .GAP_CYCLES(4), .SYNC_STAGE(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_rst_req   (sw_rst_req),
        .wdt_rst_req  (wdt_rst_req),
        .dbg_rst_req  (dbg_rst_req),
        .cause_clr    (cause_clr),
        .domain_rst_n (domain_rst_n),
        .rst_busy     (rst_busy),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int e);
        while (cyc < e) step();
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int e, input logic [2:0] dom,
                        input logic busy, input logic [3:0] cause);
        exp_t x;
        x.tag = tag; x.e = e; x.dom = dom; x.busy = busy; x.cause = cause;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            run_to(x.e);
            check({x.tag, ".dom"},   {5'b0, domain_rst_n}, {5'b0, x.dom});
            check({x.tag, ".busy"},  {7'b0, rst_busy},     {7'b0, x.busy});
            check({x.tag, ".cause"}, {4'b0, rst_cause},    {4'b0, x.cause});
        end
    endtask

    task automatic push_por(input string tag, input int b);
        push({tag, "@1"},  b + 1,  3'b000, 1'b1, 4'b0001);
        push({tag, "@17"}, b + 17, 3'b000, 1'b1, 4'b0001);
        push({tag, "@18"}, b + 18, 3'b001, 1'b1, 4'b0001);
        push({tag, "@21"}, b + 21, 3'b001, 1'b1, 4'b0001);
        push({tag, "@22"}, b + 22, 3'b011, 1'b1, 4'b0001);
        push({tag, "@25"}, b + 25, 3'b011, 1'b1, 4'b0001);
        push({tag, "@26"}, b + 26, 3'b111, 1'b0, 4'b0001);
    endtask

    initial begin
        int base, n, m, q, p;
        rst_n = 1'b0; sw_rst_req = 1'b0; wdt_rst_req = 1'b0; dbg_rst_req = 1'b0; cause_clr = 1'b0;

        // 1. power-on reset
        repeat (5) step();
        check("por_hold.dom",   {5'b0, domain_rst_n}, 8'h00);
        check("por_hold.busy",  {7'b0, rst_busy},     8'h01);
        check("por_hold.cause", {4'b0, rst_cause},    8'h01);
        rst_n = 1'b1;
        base = cyc;
        push_por("por", base);
        drain();

        // 2. cause_clr then software pulse in RUN
        run_to(base + 29);
        cause_clr = 1'b1; step(); cause_clr = 1'b0;
        push("clr", cyc, 3'b111, 1'b0, 4'b0000);
        drain();
        n = cyc + 3;
        run_to(n - 1);
        sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
        push("sw@0",  n,      3'b000, 1'b1, 4'b0010);
        push("sw@15", n + 15, 3'b000, 1'b1, 4'b0010);
        push("sw@16", n + 16, 3'b001, 1'b1, 4'b0010);
        push("sw@19", n + 19, 3'b001, 1'b1, 4'b0010);
        push("sw@20", n + 20, 3'b011, 1'b1, 4'b0010);
        push("sw@23", n + 23, 3'b011, 1'b1, 4'b0010);
        push("sw@24", n + 24, 3'b111, 1'b0, 4'b0010);
        drain();

        // 3. watchdog level held for 40 edges
        n = cyc + 5;
        run_to(n - 1);
        wdt_rst_req = 1'b1;
        push("wdt@0",  n,      3'b000, 1'b1, 4'b0110);
        push("wdt@39", n + 39, 3'b000, 1'b1, 4'b0110);
        drain();
        wdt_rst_req = 1'b0;
        push("wdt@54", n + 54, 3'b000, 1'b1, 4'b0110);
        push("wdt@55", n + 55, 3'b001, 1'b1, 4'b0110);
        drain();

        // 4. debugger pulse between domain 0 and domain 1 release
        m = n + 57;
        run_to(m - 1);
        dbg_rst_req = 1'b1; step(); dbg_rst_req = 1'b0;
        push("dbg@0",  m,      3'b000, 1'b1, 4'b1110);
        push("dbg@15", m + 15, 3'b000, 1'b1, 4'b1110);
        push("dbg@16", m + 16, 3'b001, 1'b1, 4'b1110);
        push("dbg@19", m + 19, 3'b001, 1'b1, 4'b1110);
        push("dbg@20", m + 20, 3'b011, 1'b1, 4'b1110);
        push("dbg@24", m + 24, 3'b111, 1'b0, 4'b1110);
        drain();

        // 6. chip reset asserted mid-RELEASE, then full POR timing again
        q = cyc + 5;
        run_to(q - 1);
        sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
        push("pre6@16", q + 16, 3'b001, 1'b1, 4'b1110);
        drain();
        run_to(q + 18);
        #2 rst_n = 1'b0;
        #1;
        check("async.dom",   {5'b0, domain_rst_n}, 8'h00);
        check("async.busy",  {7'b0, rst_busy},     8'h01);
        check("async.cause", {4'b0, rst_cause},    8'h01);
        repeat (5) step();
        rst_n = 1'b1;
        base = cyc;
        push_por("por2", base);
        drain();

        // 5. sw + wdt + cause_clr on one edge in RUN
        p = cyc + 5;
        run_to(p - 1);
        sw_rst_req = 1'b1; wdt_rst_req = 1'b1; cause_clr = 1'b1;
        step();
        sw_rst_req = 1'b0; wdt_rst_req = 1'b0; cause_clr = 1'b0;
        push("multi@0",  p,      3'b000, 1'b1, 4'b0110);
        push("multi@15", p + 15, 3'b000, 1'b1, 4'b0110);
        push("multi@16", p + 16, 3'b001, 1'b1, 4'b0110);
        push("multi@24", p + 24, 3'b111, 1'b0, 4'b0110);
        push("multi@40", p + 40, 3'b111, 1'b0, 4'b0110);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
